// File: rtl/kl8e_iot_responder.sv
// kl8e_iot_responder: PDP-8/e KL8E console keyboard/teleprinter IOT responder with 8N1 UART.
// Define KL8E_INTERRUPT_EN to enable the interrupt request and the KIE (6035) enable register.
module kl8e_iot_responder #(
  parameter int CLKS_PER_BIT = 868,
  parameter logic [4:0] EXEC_STATE = 5'h0B
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic [4:0]  state,
  input  logic [0:11] instruction,
  input  logic [0:11] ac,
  input  logic        UF,
  input  logic        rx,
  output logic        tx,
  output logic        skip,
  output logic [0:11] ac_out,
  output logic        ac_clr,
  output logic        ac_or,
  output logic        interrupt
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;
  st_t tx_st, tx_nx, rx_st, rx_nx;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit, fn;
  logic [7:0] tx_sh, rx_sh, kbuf;
  logic kflag, tflag, rx_s1, rx_s2;
  logic exec, kdev, tdev, tx_go, tx_end, tx_last, rx_tick, rx_ok;
  logic unused;
  assign unused = &ac[0:3];
  assign fn = instruction[9:11];
  assign exec = state == EXEC_STATE && instruction[0:2] == 3'b110 && !UF;
  assign kdev = exec && instruction[3:8] == 6'o03;
  assign tdev = exec && instruction[3:8] == 6'o04;
  assign tx_go = tdev && (fn == 3'd4 || fn == 3'd6);
  assign tx_end = tx_cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_last = tx_st == STOP && tx_end;
  assign tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
  // the start re-check lands at half a bit, so later ticks fall mid-bit
  assign rx_tick = rx_cnt == (rx_st == START ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1));
  assign rx_ok = rx_st == STOP && rx_tick && rx_s2;
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE:    tx_nx = tx_go ? START : IDLE;
      START:   tx_nx = tx_end ? DATA : START;
      DATA:    tx_nx = tx_end && tx_bit == 3'd7 ? STOP : DATA;
      default: tx_nx = tx_end ? IDLE : STOP;
    endcase
  end
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:    rx_nx = rx_s2 ? IDLE : START;
      START:   rx_nx = rx_tick ? (rx_s2 ? IDLE : DATA) : START;
      DATA:    rx_nx = rx_tick && rx_bit == 3'd7 ? STOP : DATA;
      default: rx_nx = rx_tick ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_st <= IDLE;
      rx_st <= IDLE;
      tx_cnt <= '0;
      rx_cnt <= '0;
      tx_bit <= '0;
      rx_bit <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      kbuf <= '0;
      kflag <= 1'b0;
      tflag <= 1'b0;
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      skip <= 1'b0;
      ac_out <= '0;
      ac_clr <= 1'b0;
      ac_or <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      rx_st <= rx_nx;
      tx_cnt <= tx_st == IDLE || tx_end ? '0 : tx_cnt + 1'b1;
      rx_cnt <= rx_st == IDLE || rx_tick ? '0 : rx_cnt + 1'b1;
      tx_bit <= tx_st == DATA && tx_end ? tx_bit + 1'b1 : tx_bit;
      rx_bit <= rx_st == DATA && rx_tick ? rx_bit + 1'b1 : rx_bit;
      tx_sh <= tx_st == IDLE && tx_go ? ac[4:11] : tx_st == DATA && tx_end ? tx_sh >> 1 : tx_sh;
      rx_sh <= rx_st == DATA && rx_tick ? {rx_s2, rx_sh[7:1]} : rx_sh;
      kbuf <= rx_ok ? rx_sh : kbuf;
      kflag <= rx_ok | (kflag & ~(clear | (kdev && (fn == 3'd0 || fn == 3'd2 || fn == 3'd6))));
      tflag <= tx_last | (tdev && fn == 3'd0) | (tflag & ~(clear | (tdev && (fn == 3'd2 || fn == 3'd6))));
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      skip <= kdev && fn == 3'd1 ? kflag : tdev && fn == 3'd1 ? tflag : tdev && fn == 3'd5 ? tflag | kflag : 1'b0;
      ac_out <= kdev && (fn == 3'd4 || fn == 3'd6) ? {4'b0, kbuf} : 12'o0;
      ac_clr <= kdev && (fn == 3'd2 || fn == 3'd6);
      ac_or <= kdev && (fn == 3'd4 || fn == 3'd6);
    end
  end
`ifdef KL8E_INTERRUPT_EN
  logic ie;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ie <= 1'b1;
      interrupt <= 1'b0;
    end else begin
      ie <= clear ? 1'b1 : kdev && fn == 3'd5 ? ac[11] : ie;
      interrupt <= ie & (kflag | tflag);
    end
  end
`else
  assign interrupt = 1'b0;
`endif
endmodule

// File: tb/tb_kl8e_iot_responder.sv
// tb_kl8e_iot_responder: scoreboard bench for kl8e_iot_responder with 8 clocks per bit.
module tb_kl8e_iot_responder;
  localparam logic [14:0] NONE = 15'd0;
  localparam logic [14:0] SKIP = {3'b100, 12'o0};
`ifdef KL8E_INTERRUPT_EN
  localparam logic INT_EXP = 1'b1;
`else
  localparam logic INT_EXP = 1'b0;
`endif
  logic clk = 0, resetn = 0, clear = 0, UF = 0, rx = 1;
  logic [4:0] state = 5'h00;
  logic [0:11] instruction = 12'o0, ac = 12'o0;
  logic tx, skip, ac_clr, ac_or, interrupt;
  logic [0:11] ac_out;
  int vectors = 0, miscompares = 0;
  logic [14:0] rq[$];
  logic [9:0] tq[$];
  logic [14:0] e;
  logic [9:0] f;
  logic pend = 0, prev = 0, tx_mon_off = 0;

  kl8e_iot_responder #(.CLKS_PER_BIT(8), .EXEC_STATE(5'h0B)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .state(state), .instruction(instruction),
    .ac(ac), .UF(UF), .rx(rx), .tx(tx), .skip(skip), .ac_out(ac_out), .ac_clr(ac_clr),
    .ac_or(ac_or), .interrupt(interrupt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic iot(input logic [11:0] ins, input logic [11:0] a, input logic [14:0] exp,
                     input logic uf = 1'b0, input logic [4:0] st = 5'h0B);
    @(posedge clk);
    #1 instruction = ins; ac = a; UF = uf; state = st; pend = 1; rq.push_back(exp);
    @(posedge clk);
    #1 state = 5'h00; UF = 0; pend = 0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx = 0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (8) @(posedge clk);
    end
    #1 rx = stop;
    repeat (8) @(posedge clk);
    #1 rx = 1;
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear = 1;
    @(posedge clk);
    #1 clear = 0;
  endtask

  always @(negedge clk) begin
    if (resetn && (prev || skip || ac_clr || ac_or || ac_out != 12'o0)) begin
      e = rq.size() != 0 ? rq.pop_front() : 15'd0;
      chk("iot response {skip,clr,or,ac_out}", {1'b0, skip, ac_clr, ac_or, ac_out}, {1'b0, e});
    end
    prev = pend;
  end

  initial forever begin
    @(negedge clk);
    if (resetn && !tx && !tx_mon_off) begin
      repeat (4) @(negedge clk);
      f[0] = tx;
      for (int i = 1; i < 10; i++) begin
        repeat (8) @(negedge clk);
        f[i] = tx;
      end
      if (tq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tx frame: got unexpected frame %b, expected none", f);
      end else chk("tx frame", {6'd0, f}, {6'd0, tq.pop_front()});
    end
  end

  initial begin
    #12;
    chk("reset tx/skip/clr/or/ac_out", {tx, skip, ac_clr, ac_or, ac_out}, {1'b1, 15'd0});
    chk("reset interrupt", {15'd0, interrupt}, 16'd0);
    @(posedge clk);
    #1 resetn = 1;
    repeat (3) @(posedge clk);
    iot(12'o6031, 12'o0, NONE);
    iot(12'o6041, 12'o0, NONE);
    iot(12'o6040, 12'o0, NONE);
    iot(12'o6041, 12'o0, SKIP);
    iot(12'o6042, 12'o0, NONE);
    iot(12'o6041, 12'o0, NONE);
    tq.push_back(10'b1010000010);
    iot(12'o6046, 12'o0101, NONE);
    chk("tx low after TLS", {15'd0, tx}, 16'd0);
    repeat (10) @(posedge clk);
    iot(12'o6041, 12'o0, NONE);
    iot(12'o6044, 12'o0377, NONE);
    repeat (80) @(posedge clk);
    iot(12'o6041, 12'o0, SKIP);
    iot(12'o6045, 12'o0, SKIP);
    tq.push_back(10'b1100101010);
    iot(12'o6044, 12'o7625, NONE);
    iot(12'o6041, 12'o0, SKIP);
    repeat (85) @(posedge clk);
    send_rx(8'h5A, 1'b1);
    iot(12'o6031, 12'o0, SKIP);
    iot(12'o6034, 12'o0, {3'b001, 12'o0132});
    iot(12'o6036, 12'o0, {3'b011, 12'o0132});
    iot(12'o6031, 12'o0, NONE);
    send_rx(8'h33, 1'b0);
    repeat (4) @(posedge clk);
    iot(12'o6031, 12'o0, NONE);
    iot(12'o6034, 12'o0, {3'b001, 12'o0132});
    @(posedge clk);
    #1 rx = 0;
    repeat (2) @(posedge clk);
    #1 rx = 1;
    repeat (20) @(posedge clk);
    iot(12'o6031, 12'o0, NONE);
    send_rx(8'hC3, 1'b1);
    iot(12'o6031, 12'o0, SKIP);
    iot(12'o6034, 12'o0, {3'b001, 12'o0303});
    iot(12'o6032, 12'o0, {3'b010, 12'o0});
    iot(12'o6031, 12'o0, NONE);
    fork
      send_rx(8'h0F, 1'b1);
      begin
        repeat (78) @(posedge clk);
        iot(12'o6030, 12'o0, NONE);
      end
    join
    iot(12'o6031, 12'o0, SKIP);
    iot(12'o6036, 12'o0, {3'b011, 12'o0017});
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    iot(12'o6034, 12'o0, {3'b001, 12'o0042});
    iot(12'o6031, 12'o0, SKIP);
    iot(12'o6046, 12'o0101, NONE, 1'b1);
    chk("tx idle with UF=1", {15'd0, tx}, 16'd1);
    iot(12'o6031, 12'o0, NONE, 1'b1);
    iot(12'o6046, 12'o0101, NONE, 1'b0, 5'h0A);
    chk("tx idle outside exec state", {15'd0, tx}, 16'd1);
    iot(12'o6031, 12'o0, NONE, 1'b0, 5'h0A);
    repeat (20) @(posedge clk);
    iot(12'o6041, 12'o0, SKIP);
    iot(12'o6031, 12'o0, SKIP);
    pulse_clear();
    iot(12'o6045, 12'o0, NONE);
    iot(12'o6035, 12'o0, NONE);
    send_rx(8'h41, 1'b1);
    repeat (3) @(posedge clk);
    chk("interrupt with ie=0", {15'd0, interrupt}, 16'd0);
    iot(12'o6035, 12'o0001, NONE);
    repeat (3) @(posedge clk);
    chk("interrupt with ie=1", {15'd0, interrupt}, {15'd0, INT_EXP});
    pulse_clear();
    repeat (3) @(posedge clk);
    chk("interrupt after clear", {15'd0, interrupt}, 16'd0);
    tx_mon_off = 1;
    iot(12'o6046, 12'o0125, NONE);
    repeat (20) @(posedge clk);
    #3 resetn = 0;
    #1 chk("tx high on reset mid-frame", {15'd0, tx}, 16'd1);
    chk("interrupt in reset", {15'd0, interrupt}, 16'd0);
    @(posedge clk);
    #1 resetn = 1;
    repeat (3) @(posedge clk);
    tx_mon_off = 0;
    iot(12'o6041, 12'o0, NONE);
    iot(12'o6031, 12'o0, NONE);
    iot(12'o6034, 12'o0, {3'b001, 12'o0});
    repeat (4) @(posedge clk);
    chk("response queue drained", 16'(rq.size()), 16'd0);
    chk("tx queue drained", 16'(tq.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
